// File: rtl/l2_mem_pkg.sv
// Shared definitions for the L2 memory port and its backing memory.
// Holds the default port geometry, block offset/count, the backing
// memory FSM encoding and the flat block word-select macro.
`ifndef L2_FLAT_WORD
`define L2_FLAT_WORD(flat, g, w) flat[((g)+1)*(w)-1 -: (w)]
`endif

package l2_mem_pkg;

  localparam int unsigned L2_DATA_WIDTH = 32;
  localparam int unsigned L2_ADDR_WIDTH = 11;
  localparam int unsigned L2_BLOCK_SIZE = 32;

  localparam int unsigned OFFSET_W   = $clog2(L2_BLOCK_SIZE);
  localparam int unsigned MEM_BLOCKS = 2 ** (L2_ADDR_WIDTH - OFFSET_W);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY     = 2'd1,
    COOLDOWN = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_block_array.sv
// Block-wide storage: DEPTH entries of WIDTH bits.
// Ports: clk; we/waddr/wdata synchronous write; raddr with registered rdata.
// No reset: contents survive rst_n.
module mem_block_array
  import l2_mem_pkg::*;
#(
  parameter int unsigned WIDTH = 1024,
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Single write port, single registered read port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/l2_backing_memory.sv
// Main-memory responder behind the L2 memory port with programmable latency.
// Ports: clk, rst_n (sync, active-low); mem_addr/mem_read/mem_write/
// mem_data_out_flat request from L2; mem_data_block_flat read block,
// mem_ready completion pulse, busy (state != IDLE), req_dropped sticky flag.
module l2_backing_memory
  import l2_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = L2_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH    = L2_ADDR_WIDTH,
  parameter int unsigned BLOCK_SIZE    = L2_BLOCK_SIZE,
  parameter int unsigned READ_LATENCY  = 4,
  parameter int unsigned WRITE_LATENCY = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ADDR_WIDTH-1:0]            mem_addr,
  input  logic                             mem_read,
  input  logic                             mem_write,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_out_flat,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_block_flat,
  output logic                             mem_ready,
  output logic                             busy,
  output logic                             req_dropped
);

  localparam int unsigned BLK_OFF_W = $clog2(BLOCK_SIZE);
  localparam int unsigned IDX_W     = ADDR_WIDTH - BLK_OFF_W;
  localparam int unsigned DEPTH     = 2 ** IDX_W;
  localparam int unsigned BLK_W     = BLOCK_SIZE * DATA_WIDTH;
  localparam int unsigned MAX_LAT   = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int unsigned CNT_W     = $clog2(MAX_LAT) + 1;

  mem_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             op_write;
  logic [IDX_W-1:0] idx_q;
  logic [BLK_W-1:0] wdata_q;
  logic [BLK_W-1:0] rdata;

  logic [IDX_W-1:0] req_idx_c;
  logic [IDX_W-1:0] raddr_c;
  logic             done_c;
  logic             we_c;
  logic             unused_offset_c;

  assign req_idx_c       = mem_addr[ADDR_WIDTH-1:BLK_OFF_W];
  // Word offset within a block is a don't-care
  assign unused_offset_c = ^mem_addr[BLK_OFF_W-1:0];
  assign done_c          = (state == BUSY) && (cnt == '0);
  // Commit is gated by rst_n so a reset on the completion edge aborts the write
  assign we_c            = rst_n && done_c && op_write;
  // Point the read port at the incoming address while idle so the block is
  // already registered by the time even a 1-cycle access completes
  assign raddr_c         = (state == IDLE) ? req_idx_c : idx_q;

  mem_block_array #(
    .WIDTH (BLK_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (we_c),
    .waddr (idx_q),
    .wdata (wdata_q),
    .raddr (raddr_c),
    .rdata (rdata)
  );

  // Access FSM, latency counter, request latch and sticky drop flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= IDLE;
      cnt                 <= '0;
      op_write            <= 1'b0;
      idx_q               <= '0;
      mem_ready           <= 1'b0;
      busy                <= 1'b0;
      req_dropped         <= 1'b0;
      mem_data_block_flat <= '0;
    end else begin
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          // Write wins a tie; a held read is picked up after COOLDOWN
          if (mem_write || mem_read) begin
            state    <= BUSY;
            busy     <= 1'b1;
            idx_q    <= req_idx_c;
            op_write <= mem_write;
            cnt      <= mem_write ? CNT_W'(WRITE_LATENCY - 1) : CNT_W'(READ_LATENCY - 1);
            if (mem_write) begin
              wdata_q <= mem_data_out_flat;
            end
          end
        end
        BUSY: begin
          // A held read of the in-flight block is the normal L2 level, not a drop
          if (mem_write || (mem_read && (req_idx_c != idx_q))) begin
            req_dropped <= 1'b1;
          end
          if (done_c) begin
            state     <= COOLDOWN;
            mem_ready <= 1'b1;
            if (!op_write) begin
              mem_data_block_flat <= rdata;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        COOLDOWN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
